// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, 256x16 instruction memory, IDLE/RUN/HALT control
module inst_fetch #(
  parameter int             PC_WIDTH    = 8,
  parameter int             IMEM_DEPTH  = 256,
  parameter logic [3:0]     HALT_OPCODE = 4'b1111
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                load_en,
  input  logic [PC_WIDTH-1:0] load_addr,
  input  logic [15:0]         load_data,
  input  logic                branch_taken,
  input  logic [7:0]          branch_offset,
  output logic [15:0]         instruction,
  output logic [PC_WIDTH-1:0] pc,
  output logic                inst_valid,
  output logic                halted,
  output logic [15:0]         retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [15:0]         retired_q;
  logic [15:0]         imem [IMEM_DEPTH];
  logic [15:0]         offset_ext;
  logic                is_halt;

  assign instruction = (state_q == RUN) ? imem[pc_q] : {HALT_OPCODE, 12'h000};
  assign is_halt     = (instruction[15:12] == HALT_OPCODE);
  assign inst_valid  = (state_q == RUN) && !is_halt;
  assign halted      = (state_q == HALT);
  assign pc          = pc_q;
  assign retired     = retired_q;

  // Offset is sign-extended then truncated so negative targets wrap modulo 2**PC_WIDTH.
  assign offset_ext = {{8{branch_offset[7]}}, branch_offset};

  always_comb begin
    pc_d = pc_q + PC_WIDTH'(1);
    if (branch_taken) begin
      pc_d = pc_q + PC_WIDTH'(1) + offset_ext[PC_WIDTH-1:0];
    end
  end

  // Memory is deliberately left out of reset; only the load port can change it.
  always_ff @(posedge clk) begin
    if (load_en && (state_q != RUN)) begin
      imem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (run) begin
            state_q   <= RUN;
            pc_q      <= '0;
            retired_q <= '0;
          end
        end
        RUN: begin
          if (is_halt) begin
            state_q <= HALT;
          end else begin
            pc_q <= pc_d;
            if (retired_q != 16'hFFFF) begin
              retired_q <= retired_q + 16'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
